// File: rtl/lcd_pkg.sv
// Shared constants for the 800x480 RGB888 LCD VRAM address map, plus the fill-engine state encoding.
// The scan-out controller imports this package too, so both sides use the same address map.
package lcd_pkg;

  localparam int unsigned HPXL = 800;
  localparam int unsigned VPXL = 480;
  localparam int unsigned HBW  = 10;
  localparam int unsigned VBW  = 9;
  localparam int unsigned ABW  = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_FIN
  } fillState_t;

  typedef struct packed {
    logic [HBW-1:0] x0;
    logic [VBW-1:0] y0;
    logic [HBW-1:0] w;
    logic [VBW-1:0] h;
    logic [23:0]    color;
  } fillCmd_t;

  // y*800 computed as y*512 + y*256 + y*32, so no multiplier is needed.
  function automatic logic [ABW-1:0] rowBaseOf(input logic [VBW-1:0] y);
    return (ABW'(y) << 9) + (ABW'(y) << 8) + (ABW'(y) << 5);
  endfunction

endpackage

// File: rtl/lcd_vram_fill_if.sv
// Command handshake and VRAM write-port bundle of the rectangle-fill engine.
// The slave modport is the engine; the master modport is the register block / arbiter side.
interface lcd_vram_fill_if
  import lcd_pkg::*;
();

  logic           iCMD_VALID;
  logic           oCMD_READY;
  logic [HBW-1:0] iX0;
  logic [VBW-1:0] iY0;
  logic [HBW-1:0] iW;
  logic [VBW-1:0] iH;
  logic [23:0]    iCOLOR;
  logic           iSTALL;
  logic           oWE;
  logic [ABW-1:0] oWADDR;
  logic [23:0]    oWDATA;
  logic [HBW-1:0] oHADDR;
  logic [VBW-1:0] oVADDR;
  logic           oBUSY;
  logic           oDONE;

  modport slave (
    input  iCMD_VALID, iX0, iY0, iW, iH, iCOLOR, iSTALL,
    output oCMD_READY, oWE, oWADDR, oWDATA, oHADDR, oVADDR, oBUSY, oDONE
  );

  modport master (
    output iCMD_VALID, iX0, iY0, iW, iH, iCOLOR, iSTALL,
    input  oCMD_READY, oWE, oWADDR, oWDATA, oHADDR, oVADDR, oBUSY, oDONE
  );

endinterface

// File: rtl/lcd_fill_clip.sv
// Clips a latched fill rectangle to the screen: last column/row, empty flag and the Y0*HPXL row base.
// Purely combinational; the engine registers the results during its SETUP cycle.
module lcd_fill_clip
  import lcd_pkg::*;
(
  input  logic [HBW-1:0] x0,
  input  logic [VBW-1:0] y0,
  input  logic [HBW-1:0] w,
  input  logic [VBW-1:0] h,
  output logic [HBW-1:0] xe,
  output logic [VBW-1:0] ye,
  output logic           empty,
  output logic [ABW-1:0] rowBase
);

  localparam logic [HBW:0] HLIM = (HBW+1)'(HPXL);
  localparam logic [VBW:0] VLIM = (VBW+1)'(VPXL);

  logic [HBW:0] xSum;
  logic [HBW:0] xLim;
  logic [VBW:0] ySum;
  logic [VBW:0] yLim;

  // One extra bit on the sums keeps X0+W and Y0+H from wrapping before the clamp.
  always_comb begin
    xSum    = {1'b0, x0} + {1'b0, w};
    ySum    = {1'b0, y0} + {1'b0, h};
    xLim    = (xSum > HLIM) ? HLIM : xSum;
    yLim    = (ySum > VLIM) ? VLIM : ySum;
    xe      = HBW'(xLim - (HBW+1)'(1));
    ye      = VBW'(yLim - (VBW+1)'(1));
    empty   = (w == '0) || (h == '0) || (x0 >= HBW'(HPXL)) || (y0 >= VBW'(VPXL));
    rowBase = rowBaseOf(y0);
  end

endmodule

// File: rtl/lcd_vram_fill.sv
// Rectangle-fill engine: accepts one clipped fill command and emits one VRAM write per cycle
// in raster order, holding everything while the write-port arbiter stalls.
module lcd_vram_fill
  import lcd_pkg::*;
(
  input  logic           clk,
  input  logic           rst_,
  lcd_vram_fill_if.slave bus
);

  fillState_t     stateQ, stateD;
  fillCmd_t       cmdQ, cmdD;
  logic [HBW-1:0] xQ, xD, xeQ, xeD;
  logic [VBW-1:0] yQ, yD, yeQ, yeD;
  logic [ABW-1:0] addrQ, addrD, rowBaseQ, rowBaseD;

  logic [HBW-1:0] clipXe;
  logic [VBW-1:0] clipYe;
  logic           clipEmpty;
  logic [ABW-1:0] clipRowBase;

  lcd_fill_clip uClip (
    .x0      (cmdQ.x0),
    .y0      (cmdQ.y0),
    .w       (cmdQ.w),
    .h       (cmdQ.h),
    .xe      (clipXe),
    .ye      (clipYe),
    .empty   (clipEmpty),
    .rowBase (clipRowBase)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      stateQ   <= ST_IDLE;
      cmdQ     <= '0;
      xQ       <= '0;
      yQ       <= '0;
      xeQ      <= '0;
      yeQ      <= '0;
      addrQ    <= '0;
      rowBaseQ <= '0;
    end else begin
      stateQ   <= stateD;
      cmdQ     <= cmdD;
      xQ       <= xD;
      yQ       <= yD;
      xeQ      <= xeD;
      yeQ      <= yeD;
      addrQ    <= addrD;
      rowBaseQ <= rowBaseD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    cmdD     = cmdQ;
    xD       = xQ;
    yD       = yQ;
    xeD      = xeQ;
    yeD      = yeQ;
    addrD    = addrQ;
    rowBaseD = rowBaseQ;
    case (stateQ)
      ST_IDLE: begin
        if (bus.iCMD_VALID) begin
          cmdD.x0    = bus.iX0;
          cmdD.y0    = bus.iY0;
          cmdD.w     = bus.iW;
          cmdD.h     = bus.iH;
          cmdD.color = bus.iCOLOR;
          stateD     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        xeD      = clipXe;
        yeD      = clipYe;
        rowBaseD = clipRowBase;
        if (clipEmpty) begin
          stateD = ST_FIN;
        end else begin
          xD     = cmdQ.x0;
          yD     = cmdQ.y0;
          addrD  = clipRowBase + ABW'(cmdQ.x0);
          stateD = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!bus.iSTALL) begin
          if (xQ < xeQ) begin
            xD    = xQ + HBW'(1);
            addrD = addrQ + ABW'(1);
          end else if (yQ < yeQ) begin
            // Restart each row from the running row base so a right-edge clip never wraps.
            xD       = cmdQ.x0;
            yD       = yQ + VBW'(1);
            rowBaseD = rowBaseQ + ABW'(HPXL);
            addrD    = rowBaseD + ABW'(cmdQ.x0);
          end else begin
            stateD = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  assign bus.oCMD_READY = (stateQ == ST_IDLE);
  assign bus.oBUSY      = (stateQ != ST_IDLE);
  assign bus.oWE        = (stateQ == ST_FILL);
  assign bus.oDONE      = (stateQ == ST_FIN);
  assign bus.oWADDR     = addrQ;
  assign bus.oWDATA     = cmdQ.color;
  assign bus.oHADDR     = xQ;
  assign bus.oVADDR     = yQ;

endmodule

// File: doc/lcd_vram_fill.md
Name: lcd_vram_fill

Overview:
- Hardware rectangle-fill engine: the write side of the 800x480 24-bit VRAM that the LCD scan-out controller reads.
- Accepts one fill command at a time through a valid/ready handshake and clips it to the screen.
- Emits one VRAM write per cycle in raster order (row-major, left to right) on a single write port shared with an arbiter.
- Sits between the CPU-facing register block and the VRAM write port.

Parameters:
- HPXL, 800, horizontal pixel count.
- VPXL, 480, vertical pixel count.
- HBW, 10, horizontal coordinate width (fits HPXL-1 and HPXL).
- VBW, 9, vertical coordinate width (fits VPXL-1 and VPXL).
- ABW, 19, VRAM linear address width (fits HPXL*VPXL-1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_  in  1  asynchronous, active-low reset.
- iCMD_VALID  in  1  fill command present.
- oCMD_READY  out  1  engine can accept a command.
- iX0  in  HBW  left column.
- iY0  in  VBW  top row.
- iW  in  HBW  width in pixels.
- iH  in  VBW  height in pixels.
- iCOLOR  in  24  fill colour, RGB888.
- iSTALL  in  1  arbiter refuses the current write this cycle.
- oWE  out  1  VRAM write enable.
- oWADDR  out  ABW  VRAM linear address, y*HPXL+x.
- oWDATA  out  24  VRAM write data.
- oHADDR  out  HBW  current x, debug/visibility.
- oVADDR  out  VBW  current y.
- oBUSY  out  1  command in progress.
- oDONE  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset (async assert, sync release): state IDLE; oWE=0, oWADDR=0, oWDATA=0, oHADDR=0, oVADDR=0, oBUSY=0, oDONE=0, oCMD_READY=1.
- State machine is IDLE -> SETUP -> FILL -> FIN -> IDLE.
- IDLE
  - oCMD_READY=1.
  - Handshake completes when iCMD_VALID&oCMD_READY.
  - On handshake, latch X0, Y0, W, H and COLOR, then go to SETUP. oBUSY rises in the next cycle.
- SETUP (1 cycle)
  - Compute xe = min(X0+W, HPXL)-1 and ye = min(Y0+H, VPXL)-1, using HBW+1 and VBW+1 bit intermediates (no overflow).
  - Compute row base = Y0*HPXL using shift-add: (Y0<<9)+(Y0<<8)+(Y0<<5). No multiplier.
  - Empty command (W==0, H==0, X0>=HPXL or Y0>=VPXL): go to FIN with no writes.
  - Otherwise go to FILL with x=X0, y=Y0, addr=base+X0.
- FILL
  - oWE=1, oWADDR=addr, oWDATA=COLOR, oHADDR=x, oVADDR=y.
  - A write is accepted in a cycle with oWE=1 and iSTALL=0.
  - When iSTALL=1, all outputs and counters hold.
  - On an accepted write:
    - if x<xe: x+1, addr+1;
    - else if y<ye: x=X0, y+1, rowbase+=HPXL, addr=rowbase_new+X0;
    - else go to FIN.
  - Addresses are registered outputs; no combinational path from iSTALL to oWADDR.
- FIN (1 cycle): oWE=0, oDONE=1, oBUSY=0 in the following cycle, return to IDLE.
- Latency:
  - Handshake at cycle N: first oWE at N+2.
  - With no stall, the last write is at N+1+npix and oDONE at N+2+npix.
  - Empty command: oDONE at N+2.
- oCMD_READY is 0 for the whole SETUP/FILL/FIN span. iCMD_VALID in those states is ignored and the command fields need not stay stable.
- iSTALL is ignored outside FILL.
- Clipping never wraps: a rectangle crossing the right edge writes only columns X0..HPXL-1 of each row, never the next row's start.
- Reset mid-command aborts immediately: no further writes, no oDONE.

Decomposition:
- Shared package lcd_pkg holds HPXL, VPXL, HBW, VBW, ABW and the state encoding. The LCD scan-out controller reuses the same constants so both ends agree on the address map.
- One natural sub-module: lcd_fill_clip. It is combinational/one-stage and computes xe, ye, the empty flag and the Y0*HPXL row base. All sequencing stays in lcd_vram_fill.

Test Plan:
- Single pixel X0=0,Y0=0,W=1,H=1,COLOR=0xFF0000 -> one write at addr 0 with data 0xFF0000; oWE at N+2; oDONE at N+3.
- Full screen X0=0,Y0=0,W=800,H=480 -> exactly 384000 writes; addresses 0..383999 contiguous; last oHADDR=799, oVADDR=479; one oDONE.
- Right/bottom clip X0=790,Y0=478,W=20,H=5 -> 2 rows x 10 px; addresses 383190..383199 then 383990..383999; no address >= 384000.
- Empty/off-screen command W=0, then X0=800 -> zero oWE cycles; oDONE at N+2 for each; ready returns to 1.
- Stall: 4x1 fill with iSTALL high on the 2nd write for 3 cycles -> oWADDR/oWDATA held during the stall; 4 unique addresses accepted; oDONE delayed by 3 cycles.
- Reset mid-fill: assert rst_=0 after 10 writes of a 100x1 fill -> oWE=0 immediately (async), no oDONE, oCMD_READY=1 after release; a new command then runs normally.
